multi_bank_frame_buf: RTL
=========================

// Module: multi_bank_frame_buf
// PURPOSE
//  Single-clock N-bank frame buffer; generalises the ping-pong buffer to NBANK banks.
//  Writer streams frames (i_s_last-delimited) into free banks; reader replays committed banks in FIFO order.
//  Bank handover is gated by i_swap_ok. Adds occupancy reporting and selectable overflow policy.
//  Sits between a frame producer and a frame consumer sharing i_clk.
// PARAMETERS
//  DATA_W   12   data beat width
//  DEPTH    256  words per bank (power of 2, >=2)
//  NBANK    3    number of banks (>=2)
//  DROP_OVF 0    0: truncate oversize frame; 1: discard oversize frame
// PORTS
//  i_clk       in   1                 clock, all logic on rising edge
//  i_rst       in   1                 synchronous reset, active-high
//  i_s_valid   in   1                 write beat valid
//  i_s_data    in   DATA_W            write beat data
//  i_s_last    in   1                 final beat of frame
//  o_s_ready   out  1                 write beat accepted when valid&ready
//  o_m_valid   out  1                 read beat valid
//  i_m_ready   in   1                 read beat consumed when valid&ready
//  o_m_data    out  DATA_W            read beat data
//  o_m_last    out  1                 final beat of replayed frame
//  i_swap_ok   in   1                 permits reader to claim next committed bank
//  o_fill_cnt  out  $clog2(NBANK+1)   number of committed, unreleased banks
//  o_ovf       out  1                 1-cycle pulse: oversize frame handled
// BEHAVIOUR
//  Reset: all outputs 0; write ptr, read ptr, fill count, lengths cleared; read FSM -> IDLE.
//  o_s_ready = ~i_rst & (write bank not committed); first ready in cycle after reset deassert.
//  Write: beat stored at wr_bank[wr_addr]; wr_addr++. On i_s_last: len[wr_bank]=wr_addr+1,
//   bank committed, wr_bank=(wr_bank+1)%NBANK, wr_addr=0. Wrap of bank index modulo NBANK.
//  Full: when all NBANK banks committed/in use, o_s_ready=0 until reader releases one.
//  Overflow (DEPTH-th beat without last):
//   DROP_OVF=0: treat beat as last, commit len=DEPTH, pulse o_ovf; replay marks o_m_last on it.
//   DROP_OVF=1: pulse o_ovf, keep o_s_ready=1, discard beats until i_s_last inclusive, then
//    restart same bank at wr_addr=0; no commit.
//  Read FSM: IDLE (fill_cnt==0) -> ARM (fill_cnt>0) -> STREAM when i_swap_ok=1 in ARM
//   (i_swap_ok sampled only in ARM) -> DRAIN on issuing last address -> IDLE/ARM on last handshake.
//  Latency: sync-read RAM + output register; first o_m_valid 2 cycles after ARM->STREAM.
//  Output stage is skid-free: o_m_data/o_m_last held stable while o_m_valid&~i_m_ready;
//   no bubbles when i_m_ready held 1 (one beat per cycle).
//  Release: bank freed in cycle after last-beat handshake; fill_cnt decrements, rd ptr advances.
//  Simultaneous commit and release: fill_cnt unchanged; freed bank immediately writable next cycle.
//  1-beat frame (valid&last on wr_addr 0): len=1, replays single beat with o_m_last=1.
//  i_rst mid-frame: partial frames discarded, in-flight read dropped, o_m_valid=0 next cycle.
//  i_swap_ok ignored in STREAM/DRAIN; deassert has no effect on an active replay.
// STRUCTURE
//  Shared package frame_buf_pkg: read FSM state encodings (IDLE/ARM/STREAM/DRAIN), width helpers.
//  Sub-module bank_ram: simple dual-port RAM, NBANK*DEPTH x DATA_W, 1 write/1 sync read port;
//   address = {bank, word}. Control, length table, FSMs and output register in top.
// TESTING
//  1. Reset release, swap_ok=1: write 4-beat frame 1,2,3,4(last) -> read 1,2,3,4, last on 4; fill_cnt 1->0.
//  2. NBANK=3, m_ready=0: write 3 frames -> o_s_ready=0, fill_cnt=3; 4th frame blocked until 1st replayed.
//  3. DROP_OVF=0, DEPTH=4: 6 beats no last -> o_ovf pulse on beat 4, frame len 4 with last on beat 4.
//  4. DROP_OVF=1, DEPTH=4: 6-beat frame then 2-beat frame A,B -> o_ovf once, only A,B replayed.
//  5. swap_ok=0 with committed frame -> o_m_valid stays 0; raise swap_ok -> valid 2 cycles later.
//  6. Random m_ready backpressure, reset asserted mid-replay -> all outputs 0, fill_cnt=0, data order kept pre-reset.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared types and width helpers for the multi-bank frame buffer.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ARM    = 2'd1,
        RD_STREAM = 2'd2,
        RD_DRAIN  = 2'd3
    } rd_state_e;

    // Index width for a table of n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_bank_frame_buf_bank_ram.sv
// Simple dual-port frame storage: one write port, one synchronous read port
// with read enable so the read register can hold under output backpressure.
module bank_ram
    import frame_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned NBANK  = 3
) (
    input  logic                                   i_clk,
    input  logic                                   i_we,
    input  logic [idx_w(NBANK)+idx_w(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]                      i_wdata,
    input  logic                                   i_re,
    input  logic [idx_w(NBANK)+idx_w(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]                      o_rdata
);
    localparam int unsigned WORDS = NBANK * DEPTH;

    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/multi_bank_frame_buf.sv
// N-bank frame buffer: writer fills free banks with frames, reader replays
// committed banks oldest-first once i_swap_ok grants the handover.
module multi_bank_frame_buf
    import frame_buf_pkg::*;
#(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned NBANK    = 3,
    parameter bit          DROP_OVF = 1'b0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_s_valid,
    input  logic [DATA_W-1:0]          i_s_data,
    input  logic                       i_s_last,
    output logic                       o_s_ready,
    output logic                       o_m_valid,
    input  logic                       i_m_ready,
    output logic [DATA_W-1:0]          o_m_data,
    output logic                       o_m_last,
    input  logic                       i_swap_ok,
    output logic [$clog2(NBANK+1)-1:0] o_fill_cnt,
    output logic                       o_ovf
);
    localparam int unsigned AW = idx_w(DEPTH);
    localparam int unsigned BW = idx_w(NBANK);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned FW = $clog2(NBANK + 1);

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BW'(NBANK - 1)) ? '0 : b + BW'(1);
    endfunction

    logic [BW-1:0]     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [NBANK-1:0]  commit_q, commit_d;
    logic [LW-1:0]     len_q [NBANK];
    logic [LW-1:0]     len_d [NBANK];
    logic [FW-1:0]     fill_q, fill_d;
    logic              drop_q, drop_d;
    logic              ovf_q, ovf_d;
    rd_state_e         state_q, state_d;
    logic              s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic              out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              s_ready_c, wr_fire_c, wr_full_c, commit_set_c, ram_we_c;
    logic              adv_c, last_hs_c, release_c, issue_c, at_last_c;
    logic [AW-1:0]     rd_last_addr_c;
    logic [DATA_W-1:0] ram_rdata;

    assign s_ready_c = ~i_rst & ~commit_q[wr_bank_q];
    assign wr_fire_c = i_s_valid & s_ready_c;
    assign wr_full_c = (wr_addr_q == AW'(DEPTH - 1));

    // Writer: store beats, close frames on last or on reaching bank capacity.
    always_comb begin : wr_ctrl
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        drop_d       = drop_q;
        ovf_d        = 1'b0;
        commit_set_c = 1'b0;
        ram_we_c     = 1'b0;
        len_d        = len_q;
        if (wr_fire_c) begin
            if (drop_q) begin
                if (i_s_last) begin
                    drop_d    = 1'b0;
                    wr_addr_d = '0;
                end
            end else begin
                ram_we_c = 1'b1;
                if (i_s_last || (wr_full_c && !DROP_OVF)) begin
                    commit_set_c     = 1'b1;
                    len_d[wr_bank_q] = LW'(wr_addr_q) + LW'(1);
                    wr_bank_d        = next_bank(wr_bank_q);
                    wr_addr_d        = '0;
                    ovf_d            = ~i_s_last;
                end else if (wr_full_c) begin
                    ovf_d     = 1'b1;
                    drop_d    = 1'b1;
                    wr_addr_d = '0;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
            end
        end
    end

    assign adv_c          = ~out_vld_q | i_m_ready;
    assign last_hs_c      = out_vld_q & out_last_q & i_m_ready;
    assign release_c      = (state_q == RD_DRAIN) & last_hs_c;
    assign rd_last_addr_c = AW'(len_q[rd_bank_q] - LW'(1));
    assign at_last_c      = (rd_addr_q == rd_last_addr_c);

    always_comb begin : bank_status
        commit_d = commit_q;
        if (commit_set_c) begin
            commit_d[wr_bank_q] = 1'b1;
        end
        if (release_c) begin
            commit_d[rd_bank_q] = 1'b0;
        end
        fill_d = fill_q + FW'(commit_set_c) - FW'(release_c);
    end

    // Reader FSM: addresses are issued only when the pipeline can advance.
    always_comb begin : rd_fsm
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        issue_c   = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                if (fill_q != '0) begin
                    state_d = RD_ARM;
                end
            end
            RD_ARM: begin
                if (i_swap_ok) begin
                    state_d   = RD_STREAM;
                    rd_addr_d = '0;
                end
            end
            RD_STREAM: begin
                if (adv_c) begin
                    issue_c = 1'b1;
                    if (at_last_c) begin
                        state_d = RD_DRAIN;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            RD_DRAIN: begin
                if (last_hs_c) begin
                    rd_bank_d = next_bank(rd_bank_q);
                    rd_addr_d = '0;
                    state_d   = (fill_d != '0) ? RD_ARM : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin : rd_pipe
        s1_vld_d   = s1_vld_q;
        s1_last_d  = s1_last_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        if (adv_c) begin
            s1_vld_d   = issue_c;
            s1_last_d  = issue_c & at_last_c;
            out_vld_d  = s1_vld_q;
            out_last_d = s1_last_q;
            if (s1_vld_q) begin
                out_data_d = ram_rdata;
            end
        end
    end

    bank_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NBANK  (NBANK)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we_c),
        .i_waddr ({wr_bank_q, wr_addr_q}),
        .i_wdata (i_s_data),
        .i_re    (adv_c),
        .i_raddr ({rd_bank_q, rd_addr_q}),
        .o_rdata (ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank_q  <= '0;
            wr_addr_q  <= '0;
            rd_bank_q  <= '0;
            rd_addr_q  <= '0;
            commit_q   <= '0;
            len_q      <= '{default: '0};
            fill_q     <= '0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            state_q    <= RD_IDLE;
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            rd_bank_q  <= rd_bank_d;
            rd_addr_q  <= rd_addr_d;
            commit_q   <= commit_d;
            len_q      <= len_d;
            fill_q     <= fill_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            s1_vld_q   <= s1_vld_d;
            s1_last_q  <= s1_last_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
        end
    end

    assign o_s_ready  = s_ready_c;
    assign o_m_valid  = out_vld_q;
    assign o_m_data   = out_data_q;
    assign o_m_last   = out_last_q;
    assign o_fill_cnt = fill_q;
    assign o_ovf      = ovf_q;

endmodule
